// File: rtl/bp_pkg.sv
// Shared definitions for the bimodal branch predictor: counter encodings,
// default table geometry and PC index/tag extraction helpers.
// Purely declarative; no latency or flow-control behaviour of its own.
package bp_pkg;

    // Default geometry: 64 entries, 8-bit BTB tag.
    localparam int IDX_BITS_DEF = 6;
    localparam int TAG_BITS_DEF = 8;

    // 2-bit saturating counter states; bit[1] is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Table index: word-aligned PC bits just above the byte offset.
    function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // BTB tag: the PC bits immediately above the index field.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_bits,
                                           input int tag_bits);
        return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute update and redirect signals of the branch predictor.
// Latency is defined by the predictor itself (1 cycle on both paths).
// No backpressure: every asserted valid is accepted in that cycle.
//
// Ports:
//   fetch_valid/fetch_pc                      lookup request
//   pred_valid/pred_taken/pred_target         lookup result
//   upd_valid/upd_pc/upd_jump/upd_taken/
//   upd_target/upd_pred_taken/upd_pred_target resolved branch from execute
//   mispredict/redirect_pc                    corrective redirect
interface branch_predictor_if;
    import bp_pkg::*;

    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        mispredict;
    logic [31:0] redirect_pc;

    // Pipeline side: issues lookups and updates, consumes predictions.
    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  pred_valid, pred_taken, pred_target,
        input  mispredict, redirect_pc
    );

    // Predictor side.
    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output pred_valid, pred_taken, pred_target,
        output mispredict, redirect_pc
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next-state of a 2-bit saturating branch counter (jumps force strongly-taken).
// Combinational, zero latency.
// No flow control; evaluated whenever its inputs change.
//
// Ports:
//   cur      current counter state
//   taken    resolved direction
//   force_st unconditional jump: move straight to ST
//   nxt      next counter state
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    input  logic force_st,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (force_st) begin
            nxt = ST;
        end else begin
            // Saturate at both ends; never wrap between SNT and ST.
            unique case (cur)
                SNT: nxt = taken ? WNT : SNT;
                WNT: nxt = taken ? WT  : SNT;
                WT:  nxt = taken ? ST  : WNT;
                ST:  nxt = taken ? ST  : WT;
                default: nxt = cur;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor plus direct-mapped BTB, trained from execute.
// Lookup and mispredict results both appear 1 cycle after their request.
// No backpressure: one lookup and one update are accepted every cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bp   branch_predictor_if.slave (fetch lookup, update, redirect)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int TAG_BITS = TAG_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_predictor_if.slave        bp
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Prediction state: counters and BTB valid bits are reset; tag and
    // target payloads are only meaningful behind a valid bit.
    ctr_t                ctr_q     [ENTRIES];
    logic                btb_vld_q [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
    logic [31:0]         btb_tgt_q [ENTRIES];

    // Registered outputs.
    logic        pred_valid_q;
    logic        pred_taken_q;
    logic [31:0] pred_target_q;
    logic        mispredict_q;
    logic [31:0] redirect_pc_q;

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;
    logic                f_taken;
    logic [31:0]         f_target;

    assign f_idx = IDX_BITS'(pc_idx(bp.fetch_pc, IDX_BITS));
    assign f_tag = TAG_BITS'(pc_tag(bp.fetch_pc, IDX_BITS, TAG_BITS));

    // Reads use the registered tables, so a same-cycle update to the same
    // entry is not visible until the following lookup.
    assign f_hit    = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    // A taken counter without a matching BTB entry has no target to offer,
    // so it falls through to the sequential PC.
    assign f_taken  = f_hit && ctr_q[f_idx][1];
    assign f_target = f_taken ? btb_tgt_q[f_idx] : (bp.fetch_pc + 32'd4);

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    ctr_t                u_ctr_nxt;
    logic                u_btb_wr;
    logic                u_mispredict;
    logic [31:0]         u_redirect;

    assign u_idx = IDX_BITS'(pc_idx(bp.upd_pc, IDX_BITS));
    assign u_tag = TAG_BITS'(pc_tag(bp.upd_pc, IDX_BITS, TAG_BITS));

    bp_sat_counter u_sat_counter (
        .cur      (ctr_q[u_idx]),
        .taken    (bp.upd_taken),
        .force_st (bp.upd_jump),
        .nxt      (u_ctr_nxt)
    );

    // Only taken branches and jumps carry a useful target; the allocation
    // evicts whatever alias occupied the entry. Not-taken updates never
    // touch the BTB, even on a tag mismatch.
    assign u_btb_wr = bp.upd_valid && (bp.upd_taken || bp.upd_jump);

    // Wrong direction, or right direction but wrong target.
    assign u_mispredict = (bp.upd_taken != bp.upd_pred_taken) ||
                          (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));
    assign u_redirect   = bp.upd_taken ? bp.upd_target : (bp.upd_pc + 32'd4);

    // ------------------------------------------------------------------
    // Tables
    // ------------------------------------------------------------------
    // Counters and valid bits: whole table cleared in one reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i]     <= WNT;
                btb_vld_q[i] <= 1'b0;
            end
        end else if (bp.upd_valid) begin
            // The counter trains on every resolved branch regardless of tag.
            ctr_q[u_idx] <= u_ctr_nxt;
            if (u_btb_wr) begin
                btb_vld_q[u_idx] <= 1'b1;
            end
        end
    end

    // Payloads need no reset: the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && u_btb_wr) begin
            btb_tag_q[u_idx] <= u_tag;
            btb_tgt_q[u_idx] <= bp.upd_target;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            // Idle fetch cycles drop valid/taken but keep the last target.
            pred_valid_q <= bp.fetch_valid;
            pred_taken_q <= bp.fetch_valid && f_taken;
            if (bp.fetch_valid) begin
                pred_target_q <= f_target;
            end

            // Mispredict is a single-cycle pulse; redirect_pc holds.
            mispredict_q <= bp.upd_valid && u_mispredict;
            if (bp.upd_valid) begin
                redirect_pc_q <= u_redirect;
            end
        end
    end

    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;
    assign bp.mispredict  = mispredict_q;
    assign bp.redirect_pc = redirect_pc_q;

endmodule
